// File: rtl/a5_1_pkg.sv
// Shared constants and types for the A5/1 keystream generator: register
// geometry, feedback tap masks, clock-bit positions and the session states.
package a5_1_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    RUN
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_1_lfsr.sv
// One A5/1 shift register: shifts left on step, parity of the tapped bits
// (plus an optional injected key/frame bit) enters bit 0.
module a5_1_lfsr #(
  parameter int            LEN     = 19,
  parameter logic [LEN-1:0] TAPS   = '0,
  parameter int            CLK_BIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic inj,
  output logic msb,
  output logic clk_bit
);

  logic [LEN-1:0] r;
  logic           fb;

  assign fb = (^(r & TAPS)) ^ inj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (step) begin
      r <= {r[LEN-2:0], fb};
    end
  end

  assign msb     = r[LEN-1];
  assign clk_bit = r[CLK_BIT];

endmodule

// File: rtl/a5_1_keystream_gen.sv
// A5/1 keystream generator: loads key and frame into three LFSRs, runs the
// majority-clocked warm-up, then hands out one bit per valid/ready transfer.
module a5_1_keystream_gen
  import a5_1_pkg::*;
#(
  parameter int KS_BITS    = 524288,
  parameter int MIX_CYCLES = 100,
  parameter int CNT_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  input  logic        ks_ready,
  output logic        ks_valid,
  output logic        ks_bit,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(63);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(21);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(KS_BITS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             done_nx;
  logic [63:0]      key_q;
  logic [21:0]      frame_q;
  logic [63:0]      load_word;
  logic             accept, xfer, loading, maj_clk, maj, inj;
  logic [2:0]       msb, cbit, step;

  assign accept    = (state == IDLE) && start;
  assign xfer      = (state == RUN) && ks_ready;
  assign loading   = (state == LOAD_KEY) || (state == LOAD_FRAME);
  assign maj_clk   = (state == MIX) || xfer;
  assign load_word = (state == LOAD_KEY) ? key_q : {42'b0, frame_q};
  assign inj       = loading & load_word[cnt[5:0]];
  assign maj       = maj3(cbit[0], cbit[1], cbit[2]);

  // Loading steps every register; afterwards only those agreeing with the majority move.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      step[i] = loading | (maj_clk & (cbit[i] == maj));
    end
  end

  a5_1_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(clk), .rst_n(rst_n), .clr(accept), .step(step[0]), .inj(inj),
    .msb(msb[0]), .clk_bit(cbit[0])
  );

  a5_1_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(clk), .rst_n(rst_n), .clr(accept), .step(step[1]), .inj(inj),
    .msb(msb[1]), .clk_bit(cbit[1])
  );

  a5_1_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(clk), .rst_n(rst_n), .clr(accept), .step(step[2]), .inj(inj),
    .msb(msb[2]), .clk_bit(cbit[2])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      frame_q <= '0;
    end else if (accept) begin
      key_q   <= key;
      frame_q <= frame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  // The counter restarts from zero on every state change and holds while stalled.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD_KEY;
          cnt_nx   = '0;
        end
      end
      LOAD_KEY: begin
        if (cnt == KEY_LAST) begin
          state_nx = LOAD_FRAME;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LOAD_FRAME: begin
        if (cnt == FRAME_LAST) begin
          state_nx = MIX;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      MIX: begin
        if (cnt == MIX_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (ks_ready) begin
          if (cnt == RUN_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign ks_valid = (state == RUN);
  assign ks_bit   = ks_valid & (msb[0] ^ msb[1] ^ msb[2]);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_a5_1_keystream_gen.sv
// Bench for a5_1_keystream_gen: a bit-level A5/1 reference model checked on
// every transfer, pinned against the published test vector.
module tb_a5_1_keystream_gen;

  localparam int NMODEL = 150;
  localparam logic [63:0]  K1  = 64'hEFCDAB8967452312;
  localparam logic [21:0]  F1  = 22'h134;
  localparam logic [63:0]  K2  = 64'h0123456789ABCDEF;
  localparam logic [21:0]  F2  = 22'h2A5A5;
  localparam logic [119:0] REF = 120'h534EAA582FE8151AB6E1855A728C00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic        start_a = 1'b0, ready_a = 1'b0;
  logic        start_b = 1'b0, ready_b = 1'b0;
  logic        valid_a, bit_a, busy_a, done_a;
  logic        valid_b, bit_b, busy_b, done_b;

  int tests = 0;
  int fails = 0;

  bit          model_ks [0:NMODEL-1];
  bit          dut_bits [0:NMODEL-1];
  bit          en_a = 0, en_b = 0;
  int          idx_a = 0, idx_b = 0, done_cnt = 0;
  bit          stall_a = 0;
  logic        prev_bit_a = 1'b0;

  always #5 clk = ~clk;

  a5_1_keystream_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .key(key), .frame(frame),
    .ks_ready(ready_a), .ks_valid(valid_a), .ks_bit(bit_a), .busy(busy_a), .done(done_a)
  );

  a5_1_keystream_gen #(.KS_BITS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key(key), .frame(frame),
    .ks_ready(ready_b), .ks_valid(valid_b), .ks_bit(bit_b), .busy(busy_b), .done(done_b)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] stepR1(input logic [18:0] r, input logic i);
    return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13] ^ i};
  endfunction

  function automatic logic [21:0] stepR2(input logic [21:0] r, input logic i);
    return {r[20:0], r[21] ^ r[20] ^ i};
  endfunction

  function automatic logic [22:0] stepR3(input logic [22:0] r, input logic i);
    return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7] ^ i};
  endfunction

  // Reference A5/1: load key, load frame, discard 100 majority steps, then step-and-read.
  task automatic computeModel(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic        m;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 64; i++) begin
      a = stepR1(a, k[i]); b = stepR2(b, k[i]); c = stepR3(c, k[i]);
    end
    for (int i = 0; i < 22; i++) begin
      a = stepR1(a, f[i]); b = stepR2(b, f[i]); c = stepR3(c, f[i]);
    end
    for (int i = 0; i < 100 + NMODEL; i++) begin
      m = (int'(a[8]) + int'(b[10]) + int'(c[10])) >= 2;
      if (a[8] == m)  a = stepR1(a, 1'b0);
      if (b[10] == m) b = stepR2(b, 1'b0);
      if (c[10] == m) c = stepR3(c, 1'b0);
      if (i >= 100) model_ks[i-100] = a[18] ^ b[21] ^ c[22];
    end
  endtask

  task automatic applyStimulus(input logic [63:0] k, input logic [21:0] f, input bit which_b);
    key = k;
    frame = f;
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Every accepted bit is compared with the model; stalled bits must hold.
  always @(negedge clk) begin
    if (!valid_a) checkOutput("bit_a_idle_zero", 128'(bit_a), 128'(0));
    if (en_a && valid_a) begin
      if (stall_a) checkOutput("stall_hold", 128'(bit_a), 128'(prev_bit_a));
      if (ready_a) begin
        if (idx_a < NMODEL) begin
          checkOutput($sformatf("ks_bit_a[%0d]", idx_a), 128'(bit_a), 128'(model_ks[idx_a]));
          dut_bits[idx_a] = bit_a;
        end
        idx_a++;
      end
      stall_a = !ready_a;
      prev_bit_a = bit_a;
    end else begin
      stall_a = 0;
    end
    if (en_b && valid_b && ready_b) begin
      checkOutput($sformatf("ks_bit_b[%0d]", idx_b), 128'(bit_b), 128'(model_ks[idx_b % 16]));
      idx_b++;
    end
    if (done_b) done_cnt++;
  end

  initial begin
    logic [113:0] vec;
    int lat, cyc, vcount;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 128'({valid_a, bit_a, busy_a, done_a}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    computeModel(K1, F1);
    for (int i = 0; i < 114; i++) vec[113-i] = model_ks[i];
    checkOutput("model_vs_vector", 128'(vec), 128'(REF >> 6));

    // Known vector, latency, and starts that arrive while busy.
    ready_a = 1'b1;
    idx_a = 0;
    key = K1; frame = F1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!valid_a && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 120) begin key = K2; frame = F2; start_a = 1'b1; end
      if (lat == 121) start_a = 1'b0;
    end
    checkOutput("first_valid_latency", 128'(lat), 128'(187));
    en_a = 1;
    cyc = 0;
    while (idx_a < NMODEL && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      start_a = (cyc == 20);
    end
    start_a = 1'b0;
    checkOutput("vector_bits_done", 128'(idx_a >= NMODEL), 128'(1));
    for (int i = 0; i < 114; i++) vec[113-i] = dut_bits[i];
    checkOutput("dut_vs_vector", 128'(vec), 128'(REF >> 6));
    en_a = 0;

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", 128'({valid_a, bit_a, busy_a, done_a}), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (valid_a || busy_a) vcount++;
    end
    checkOutput("idle_after_reset", 128'(vcount), 128'(0));

    // Backpressure: same key, random ready.
    idx_a = 0;
    en_a = 1;
    applyStimulus(K1, F1, 1'b0);
    cyc = 0;
    while (idx_a < NMODEL && cyc < 3000) begin
      ready_a = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("backpressure_bits_done", 128'(idx_a >= NMODEL), 128'(1));
    en_a = 0;
    ready_a = 1'b1;

    // Short build: 16 transfers, done, restart on the done cycle.
    done_cnt = 0;
    idx_b = 0;
    en_b = 1;
    ready_b = 1'b1;
    applyStimulus(K1, F1, 1'b1);
    cyc = 0;
    while (!done_b && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("done_seen_1", 128'(done_b), 128'(1));
    checkOutput("transfers_1", 128'(idx_b), 128'(16));
    checkOutput("busy_at_done", 128'(busy_b), 128'(0));
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checkOutput("restart_on_done", 128'({busy_b, done_b}), 128'(2'b10));
    cyc = 0;
    while (!done_b && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("done_seen_2", 128'(done_b), 128'(1));
    checkOutput("transfers_2", 128'(idx_b), 128'(32));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_pulses", 128'(done_cnt), 128'(2));
    checkOutput("busy_after_16", 128'({busy_b, valid_b}), 128'(0));
    en_b = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
